// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
// Shared constants, command/state encodings and the symbol reduction helper
// for the game board (board_grid) and its LFSR (lfsr16).
// No ports: imported by the RTL files with import board_pkg::*.
// ---------------------------------------------------------------------------
package board_pkg;

    // Board geometry (defaults for board_grid parameters)
    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int CELL     = 32;
    localparam int ORIGIN_X = 192;
    localparam int ORIGIN_Y = 112;

    // Random symbol generation
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam int          NUM_SYMBOLS = 5;

    // Code shown for pixels outside the board
    localparam logic [2:0] VALUE_NONE = 3'd7;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FILL  = 2'b01,
        OP_SWAP  = 2'b10,
        OP_WRITE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Fold a 3-bit random value 0..7 onto the symbol range 0..4.
    function automatic logic [2:0] sym_from_rand(input logic [2:0] r);
        return (r < 3'(NUM_SYMBOLS)) ? r : (r - 3'(NUM_SYMBOLS));
    endfunction

endpackage

// File: rtl/board_grid_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit right-shifting Galois LFSR, advances every clock cycle.
// Ports:
//   clk     in   system clock
//   reset_n in   asynchronous active-low reset (loads SEED)
//   state   out  current 16-bit LFSR contents
// SEED must be nonzero, otherwise the register stays stuck at zero.
// ---------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] state
);
    import board_pkg::*;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right; the bit falling out of position 0 toggles the tap bits.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/board_grid.sv
// ---------------------------------------------------------------------------
// board_grid
// Game board of ROWS x COLS cells, 3-bit symbol code per cell.
//   Pixel side : registered lookup (latency 1) of the cell under the VGA
//                pixel, with the cell's top-left corner for the renderer.
//   Game side  : FILL / SWAP / WRITE commands over valid/ready, done pulse
//                on completion, plus a combinational random-access read port.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   pixel_x, pixel_y        in     current VGA column / row
//   pixel_x_d, pixel_y_d    out    pixel coordinates delayed one cycle
//   value                   out    symbol under the pixel (7 when outside)
//   top_left_x, top_left_y  out    corner of the cell under the pixel
//   in_board                out    pixel lies inside the board
//   cmd_valid / cmd_ready          command handshake
//   cmd_op                  in     00 NOP, 01 FILL, 10 SWAP, 11 WRITE
//   cmd_a_row/col, cmd_b_row/col   cell coordinates (B used by SWAP only)
//   cmd_value               in     WRITE data (stored as given, 0..7)
//   done                    out    one-cycle pulse when a command completes
//   rd_row, rd_col, rd_value       combinational read port
// After reset the board fills itself with random symbols and pulses done.
// ---------------------------------------------------------------------------
module board_grid #(
    parameter int          ROWS      = board_pkg::ROWS,
    parameter int          COLS      = board_pkg::COLS,
    parameter int          CELL      = board_pkg::CELL,
    parameter int          ORIGIN_X  = board_pkg::ORIGIN_X,
    parameter int          ORIGIN_Y  = board_pkg::ORIGIN_Y,
    parameter logic [15:0] LFSR_SEED = board_pkg::LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [9:0] pixel_x_d,
    output logic [9:0] pixel_y_d,
    output logic [2:0] value,
    output logic [9:0] top_left_x,
    output logic [9:0] top_left_y,
    output logic       in_board,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_a_row,
    input  logic [2:0] cmd_a_col,
    input  logic [2:0] cmd_b_row,
    input  logic [2:0] cmd_b_col,
    input  logic [2:0] cmd_value,
    output logic       done,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [2:0] rd_value
);
    import board_pkg::*;

    localparam int NCELLS = ROWS * COLS;
    localparam int IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    // -----------------------------------------------------------------------
    // Random symbol source
    // -----------------------------------------------------------------------
    logic [15:0] lfsr_state;
    logic [2:0]  fill_sym;
    logic        unused_lfsr_hi;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (lfsr_state)
    );

    assign fill_sym       = sym_from_rand(lfsr_state[2:0]);
    assign unused_lfsr_hi = ^lfsr_state[15:3];

    // -----------------------------------------------------------------------
    // Command FSM
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             accept;
    logic             fill_we;
    logic             exec_we_a;
    logic             exec_we_b;

    op_t        op_q;
    logic [2:0] a_row_q, a_col_q, b_row_q, b_col_q, wval_q;

    logic             a_ok, b_ok;
    logic [IDX_W-1:0] a_idx, b_idx;

    logic [2:0] cells [NCELLS];
    logic [2:0] a_wdata, b_wdata;

    // Coordinates outside a smaller-than-8x8 board would alias onto other
    // cells, so such commands are simply not applied.
    assign a_ok  = (int'(a_row_q) < ROWS) && (int'(a_col_q) < COLS);
    assign b_ok  = (int'(b_row_q) < ROWS) && (int'(b_col_q) < COLS);
    assign a_idx = IDX_W'(int'(a_row_q) * COLS + int'(a_col_q));
    assign b_idx = IDX_W'(int'(b_row_q) * COLS + int'(b_col_q));

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        accept     = 1'b0;
        fill_we    = 1'b0;
        exec_we_a  = 1'b0;
        exec_we_b  = 1'b0;
        case (state_q)
            ST_FILL: begin
                fill_we    = 1'b1;
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == IDX_W'(NCELLS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (op_t'(cmd_op) == OP_FILL) begin
                        state_d    = ST_FILL;
                        fill_cnt_d = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_SWAP: begin
                        exec_we_a = a_ok && b_ok;
                        exec_we_b = a_ok && b_ok;
                    end
                    OP_WRITE: exec_we_a = a_ok;
                    default:  ;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // All command fields are captured on accept so the requester may change
    // them freely while the command executes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_NOP;
            a_row_q <= '0;
            a_col_q <= '0;
            b_row_q <= '0;
            b_col_q <= '0;
            wval_q  <= '0;
        end else if (accept) begin
            op_q    <= op_t'(cmd_op);
            a_row_q <= cmd_a_row;
            a_col_q <= cmd_a_col;
            b_row_q <= cmd_b_row;
            b_col_q <= cmd_b_col;
            wval_q  <= cmd_value;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);

    // -----------------------------------------------------------------------
    // Cell storage: one register per cell with its own write decode. Both
    // swap halves read the old contents, so a swap of a cell with itself
    // rewrites the same value.
    // -----------------------------------------------------------------------
    assign a_wdata = (op_q == OP_SWAP) ? cells[b_idx] : wval_q;
    assign b_wdata = cells[a_idx];

    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
        logic [2:0] cell_q, cell_d;

        always_comb begin
            cell_d = cell_q;
            if (fill_we && (fill_cnt_q == IDX_W'(gi))) begin
                cell_d = fill_sym;
            end
            if (exec_we_a && (a_idx == IDX_W'(gi))) begin
                cell_d = a_wdata;
            end
            if (exec_we_b && (b_idx == IDX_W'(gi))) begin
                cell_d = b_wdata;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cell_q <= 3'd0;
            end else begin
                cell_q <= cell_d;
            end
        end

        assign cells[gi] = cell_q;
    end

    // -----------------------------------------------------------------------
    // Random-access read port
    // -----------------------------------------------------------------------
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;

    assign rd_ok    = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    assign rd_idx   = IDX_W'(int'(rd_row) * COLS + int'(rd_col));
    assign rd_value = rd_ok ? cells[rd_idx] : VALUE_NONE;

    // -----------------------------------------------------------------------
    // Pixel lookup, registered. Reads cells_q, so a cell written in the same
    // cycle shows its old contents.
    // -----------------------------------------------------------------------
    int               px_rel, py_rel;
    int               pix_col, pix_row;
    logic             pix_inside;
    logic [IDX_W-1:0] pix_idx;

    always_comb begin
        px_rel     = int'(pixel_x) - ORIGIN_X;
        py_rel     = int'(pixel_y) - ORIGIN_Y;
        pix_inside = (px_rel >= 0) && (px_rel < COLS * CELL) &&
                     (py_rel >= 0) && (py_rel < ROWS * CELL);
        pix_col    = 0;
        pix_row    = 0;
        if (pix_inside) begin
            pix_col = px_rel / CELL;
            pix_row = py_rel / CELL;
        end
        pix_idx = IDX_W'(pix_row * COLS + pix_col);
    end

    logic [9:0] pixel_x_q, pixel_y_q;
    logic [9:0] top_left_x_q, top_left_y_q;
    logic [2:0] value_q;
    logic       in_board_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x_q    <= '0;
            pixel_y_q    <= '0;
            top_left_x_q <= '0;
            top_left_y_q <= '0;
            value_q      <= VALUE_NONE;
            in_board_q   <= 1'b0;
        end else begin
            pixel_x_q <= pixel_x;
            pixel_y_q <= pixel_y;
            if (pix_inside) begin
                value_q      <= cells[pix_idx];
                top_left_x_q <= 10'(ORIGIN_X + pix_col * CELL);
                top_left_y_q <= 10'(ORIGIN_Y + pix_row * CELL);
                in_board_q   <= 1'b1;
            end else begin
                // corner outputs keep the last cell so the renderer sees no glitch
                value_q    <= VALUE_NONE;
                in_board_q <= 1'b0;
            end
        end
    end

    assign pixel_x_d  = pixel_x_q;
    assign pixel_y_d  = pixel_y_q;
    assign top_left_x = top_left_x_q;
    assign top_left_y = top_left_y_q;
    assign value      = value_q;
    assign in_board   = in_board_q;

endmodule

// File: tb/tb_board_grid.sv
// ---------------------------------------------------------------------------
// tb_board_grid
// Self-checking bench for board_grid: a behavioural model of the board
// (integer array + precomputed LFSR sequence indexed by clock edge) is
// compared against the read port, pixel outputs and command timing.
// ---------------------------------------------------------------------------
module tb_board_grid;

    localparam int NR      = 8;
    localparam int NC      = 8;
    localparam int CS      = 32;
    localparam int OX      = 192;
    localparam int OY      = 112;
    localparam int SEQ_LEN = 8192;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic [9:0] pixel_x_d, pixel_y_d, top_left_x, top_left_y;
    logic [2:0] value;
    logic       in_board;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_a_row = '0, cmd_a_col = '0, cmd_b_row = '0, cmd_b_col = '0;
    logic [2:0] cmd_value = '0;
    logic       done;
    logic [2:0] rd_row = '0, rd_col = '0;
    logic [2:0] rd_value;

    always #100 clk = ~clk;

    board_grid dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_x_d  (pixel_x_d),
        .pixel_y_d  (pixel_y_d),
        .value      (value),
        .top_left_x (top_left_x),
        .top_left_y (top_left_y),
        .in_board   (in_board),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a_row  (cmd_a_row),
        .cmd_a_col  (cmd_a_col),
        .cmd_b_row  (cmd_b_row),
        .cmd_b_col  (cmd_b_col),
        .cmd_value  (cmd_value),
        .done       (done),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_value   (rd_value)
    );

    int total = 0;
    int bad   = 0;

    // lfsr_seq[k] = LFSR contents after k shifts from the seed
    int unsigned lfsr_seq [SEQ_LEN];
    int          model [NR*NC];
    int          edge_cnt;
    int          model_tlx = 0, model_tly = 0;
    int          prev_px = 0, prev_py = 0;

    // rising edges since reset release; at a falling edge the LFSR holds lfsr_seq[edge_cnt]
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sym_of(input int unsigned s);
        int r;
        r = s % 8;
        return (r < 5) ? r : r - 5;
    endfunction

    // Fill whose first write happens on rising edge start+1 (LFSR = lfsr_seq[start])
    task automatic model_fill(input int start);
        for (int j = 0; j < NR*NC; j++) begin
            if (start + j < SEQ_LEN) model[j] = sym_of(lfsr_seq[start + j]);
            else check("seq_range", 0, 1);
        end
    endtask

    // Read every cell through rd port; called just after a falling edge.
    task automatic check_board(input string tag);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                rd_row = 3'(r);
                rd_col = 3'(c);
                #1;
                check($sformatf("%s rd(%0d,%0d)", tag, r, c), rd_value, model[r*NC + c]);
            end
        end
    endtask

    // Issue one command and follow it to completion.
    task automatic do_cmd(input int op, input int ar, input int ac, input int br,
                          input int bc, input int val, input string tag);
        int  acc_edge, waited, tmp;
        bit  got_done;
        cmd_op    = 2'(op);
        cmd_a_row = 3'(ar);
        cmd_a_col = 3'(ac);
        cmd_b_row = 3'(br);
        cmd_b_col = 3'(bc);
        cmd_value = 3'(val);
        cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            check({tag, " ready_timeout"}, 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acc_edge  = edge_cnt;
        cmd_valid = 1'b0;
        check({tag, " busy"}, cmd_ready, 0);
        case (op)
            1: model_fill(acc_edge);
            2: begin
                tmp = model[ar*NC + ac];
                model[ar*NC + ac] = model[br*NC + bc];
                model[br*NC + bc] = tmp;
            end
            3: model[ar*NC + ac] = val;
            default: ;
        endcase
        waited   = 0;
        got_done = 0;
        while (!got_done && waited < 100) begin
            if (done === 1'b1) got_done = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        // done seen here is sampled by a consumer on the next rising edge
        check({tag, " done_latency"}, got_done ? (edge_cnt + 1 - acc_edge) : -1,
              (op == 1) ? NR*NC + 1 : 2);
        @(negedge clk);
        check({tag, " done_width"}, done, 0);
        check({tag, " ready_back"}, cmd_ready, 1);
        $display("cmd %s op=%0d a=(%0d,%0d) b=(%0d,%0d) v=%0d accepted at edge %0d",
                 tag, op, ar, ac, br, bc, val, acc_edge);
    endtask

    // Drive a pixel, verify the one-cycle pipeline against the model.
    task automatic pix(input int px, input int py, input string tag);
        bit ins;
        int ev;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        #1;
        check({tag, " xd_before"}, pixel_x_d, prev_px);
        @(negedge clk);
        ins = (px >= OX) && (px < OX + NC*CS) && (py >= OY) && (py < OY + NR*CS);
        ev  = 7;
        if (ins) begin
            model_tlx = OX + ((px - OX) / CS) * CS;
            model_tly = OY + ((py - OY) / CS) * CS;
            ev = model[((py - OY) / CS) * NC + (px - OX) / CS];
        end
        check({tag, " xd"}, pixel_x_d, px);
        check({tag, " yd"}, pixel_y_d, py);
        check({tag, " in_board"}, in_board, ins);
        check({tag, " value"}, value, ev);
        check({tag, " tlx"}, top_left_x, model_tlx);
        check({tag, " tly"}, top_left_y, model_tly);
        $display("pix %s (%0d,%0d) in=%0d val=%0d tl=(%0d,%0d)",
                 tag, px, py, in_board, value, top_left_x, top_left_y);
        prev_px = px;
        prev_py = py;
    endtask

    initial begin
        int dones, first_done, n_acc, waited;
        int acc_e [3];
        bit drop;
        int op, ar, ac, br, bc, val;

        lfsr_seq[0] = 32'hACE1;
        for (int k = 1; k < SEQ_LEN; k++) begin
            lfsr_seq[k] = (lfsr_seq[k-1] >> 1) ^ ((lfsr_seq[k-1] & 1) ? 32'hB400 : 32'h0);
        end
        for (int j = 0; j < NR*NC; j++) model[j] = 0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst cmd_ready", cmd_ready, 0);
        check("rst done", done, 0);
        check("rst value", value, 7);
        check("rst in_board", in_board, 0);
        check("rst tlx", top_left_x, 0);
        check("rst tly", top_left_y, 0);
        check("rst xd", pixel_x_d, 0);
        check("rst yd", pixel_y_d, 0);
        check_board("rst");

        // ---------------- post-reset fill ----------------
        reset_n    = 1'b1;
        dones      = 0;
        first_done = -1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = edge_cnt;
            end
        end
        check("init done_count", dones, 1);
        check("init done_latency", first_done + 1, NR*NC + 1);
        check("init ready", cmd_ready, 1);
        model_fill(0);
        check_board("init");
        $display("init fill done after %0d edges", first_done + 1);

        // ---------------- directed WRITE + pixel ----------------
        do_cmd(3, 2, 3, 0, 0, 4, "wr23");
        check_board("wr23");
        pix(OX + 100, OY + 70, "p_wr23");
        check("p_wr23 tlx_abs", top_left_x, 288);
        check("p_wr23 tly_abs", top_left_y, 176);

        // ---------------- directed SWAP ----------------
        do_cmd(3, 0, 0, 0, 0, 1, "wr00");
        do_cmd(3, 0, 1, 0, 0, 3, "wr01");
        do_cmd(2, 0, 0, 0, 1, 0, "sw0001");
        rd_row = 3'd0; rd_col = 3'd0; #1;
        check("sw (0,0)", rd_value, 3);
        rd_col = 3'd1; #1;
        check("sw (0,1)", rd_value, 1);
        do_cmd(2, 5, 5, 5, 5, 0, "sw55");
        check_board("sw55");

        // ---------------- pixel sweep ----------------
        pix(191, 112, "p_left");
        pix(448, 200, "p_right");
        pix(192, 112, "p_corner");
        check("p_corner tlx_abs", top_left_x, 192);
        check("p_corner tly_abs", top_left_y, 112);
        pix(447, 367, "p_far");
        check("p_far tlx_abs", top_left_x, 416);
        check("p_far tly_abs", top_left_y, 336);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) pix($urandom_range(0, 639), $urandom_range(0, 479), "p_rnd");
            else pix($urandom_range(OX - 4, OX + NC*CS + 3), $urandom_range(OY - 4, OY + NR*CS + 3), "p_rnd");
        end

        // ---------------- random commands ----------------
        for (int k = 0; k < 30; k++) begin
            op  = $urandom_range(0, 7);
            op  = (op == 0) ? 1 : (op <= 2) ? 0 : (op <= 4) ? 2 : 3;
            ar  = $urandom_range(0, 7);
            ac  = $urandom_range(0, 7);
            br  = ($urandom_range(0, 4) == 0) ? ar : $urandom_range(0, 7);
            bc  = (br == ar) ? ac : $urandom_range(0, 7);
            val = $urandom_range(0, 7);
            do_cmd(op, ar, ac, br, bc, val, "rnd");
            check_board("rnd");
            pix($urandom_range(OX, OX + NC*CS - 1), $urandom_range(OY, OY + NR*CS - 1), "p_cmd");
        end

        // ---------------- FILL held during a running FILL ----------------
        cmd_op    = 2'd1;
        cmd_valid = 1'b1;
        dones     = 0;
        n_acc     = 0;
        for (int k = 0; k < 220; k++) begin
            if (done === 1'b1) dones++;
            drop = 0;
            if (cmd_ready === 1'b1 && cmd_valid === 1'b1) begin
                if (n_acc < 3) acc_e[n_acc] = edge_cnt + 1;
                n_acc++;
                drop = (n_acc >= 2);
            end
            @(negedge clk);
            if (drop) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("dfill accepts", n_acc, 2);
        check("dfill dones", dones, 2);
        if (n_acc >= 2) begin
            check("dfill gap", acc_e[1] - acc_e[0], NR*NC + 2);
            model_fill(acc_e[1]);
            check_board("dfill");
        end
        $display("double fill: accepts=%0d dones=%0d", n_acc, dones);

        // ---------------- reset during FILL ----------------
        cmd_op    = 2'd1;
        cmd_valid = 1'b1;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rfill ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rfill cmd_ready", cmd_ready, 0);
        check("rfill done", done, 0);
        for (int j = 0; j < NR*NC; j++) model[j] = 0;
        check_board("rfill_rst");
        repeat (3) @(negedge clk);
        reset_n    = 1'b1;
        dones      = 0;
        first_done = -1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = edge_cnt;
            end
        end
        check("rfill done_count", dones, 1);
        check("rfill done_latency", first_done + 1, NR*NC + 1);
        model_fill(0);
        check_board("rfill");
        $display("refill after reset done after %0d edges", first_done + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_grid.md
Name: board_grid

Overview:
- Holds the game board: ROWS x COLS cells, 3-bit symbol code each (0..4).
- Pixel side: converts VGA pixel_x/pixel_y into a cell lookup. Drives value, top_left_x and top_left_y straight into the per-cell symbol renderer downstream.
- Game side: accepts FILL / SWAP / WRITE commands over a valid/ready handshake and exposes a random-access read port for match logic.

Parameters:
- ROWS, 8, board rows; power of two, ≤8.
- COLS, 8, board columns; power of two, ≤8.
- CELL, 32, cell size in pixels; must be 32 to match the symbol footprint.
- ORIGIN_X, 192, left pixel of the board.
- ORIGIN_Y, 112, top pixel of the board.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current VGA column
- pixel_y  in  10  current VGA row
- pixel_x_d  out  10  pixel_x delayed 1 cycle (aligned with outputs)
- pixel_y_d  out  10  pixel_y delayed 1 cycle
- value  out  3  symbol code of the cell under the pixel
- top_left_x  out  10  cell left edge
- top_left_y  out  10  cell top edge
- in_board  out  1  pixel lies inside the board
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 NOP, 01 FILL, 10 SWAP, 11 WRITE
- cmd_a_row  in  3  cell A row
- cmd_a_col  in  3  cell A column
- cmd_b_row  in  3  cell B row (SWAP only)
- cmd_b_col  in  3  cell B column (SWAP only)
- cmd_value  in  3  WRITE data
- done  out  1  one-cycle pulse when a command completes
- rd_row  in  3  read-port row
- rd_col  in  3  read-port column
- rd_value  out  3  combinational read of cell (rd_row, rd_col)

Behaviour:
- Reset (reset_n low, asynchronous):
  - All cells = 0; LFSR = LFSR_SEED; FSM = FILL with fill counter = 0.
  - Outputs: cmd_ready=0, done=0, value=7, in_board=0, top_left_x/y=0, pixel_x_d/y_d=0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle in all states.
- Random symbol: r = lfsr[2:0]; sym = r if r<5, otherwise r-5.
- Pixel path, registered, latency 1:
  - dx = pixel_x - ORIGIN_X; dy = pixel_y - ORIGIN_Y.
  - Inside iff pixel_x ≥ ORIGIN_X, pixel_x < ORIGIN_X + COLS*CELL, pixel_y ≥ ORIGIN_Y, pixel_y < ORIGIN_Y + ROWS*CELL.
  - Inside: col = dx[7:5], row = dy[7:5]; value = cell[row][col]; top_left_x = ORIGIN_X + col*32; top_left_y = ORIGIN_Y + row*32; in_board=1.
  - Outside: value=7, in_board=0, top_left_x/y hold their last values.
  - On a cycle where a cell is also being written, the pixel path reads the pre-write contents.
- FSM states:
  - FILL: writes sym to cell index fill_cnt (row-major: row = cnt/COLS, col = cnt%COLS), one cell per cycle, fill_cnt increments. After cell ROWS*COLS-1 → DONE. cmd_ready=0.
  - IDLE: cmd_ready=1. cmd_valid & cmd_ready latches all cmd_* fields, then:
    - op FILL → FILL with fill_cnt=0.
    - other ops → EXEC.
  - EXEC (1 cycle):
    - SWAP: cell A ← old B and cell B ← old A in the same cycle. A == B leaves the board unchanged.
    - WRITE: cell A ← cmd_value; values 5..7 are stored as-is.
    - NOP: no change.
    - → DONE.
  - DONE (1 cycle): done=1, cmd_ready=0 → IDLE.
- Latencies: WRITE/SWAP/NOP done arrives 2 cycles after the accept edge; FILL done arrives ROWS*COLS+1 cycles after accept.
- Post-reset FILL also ends with a done pulse.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold it until accepted.
- rd_value: pure combinational read of current contents; reflects an EXEC write from the following cycle on.
- Reset asserted mid-command: the command is abandoned, the board is zeroed, and a fresh FILL runs after release.

Decomposition:
- Shared package (board_pkg):
  - constants ROWS, COLS, CELL, ORIGIN_X, ORIGIN_Y, NUM_SYMBOLS=5, VALUE_NONE=3'd7;
  - op encodings OP_NOP/OP_FILL/OP_SWAP/OP_WRITE;
  - FSM state encodings FILL/IDLE/EXEC/DONE.
- One sub-module: lfsr16 (clk, reset_n, seed parameter, 16-bit state out); the mod-5 reduction stays in board_grid.

Test Plan:
- Reset release, wait 65 cycles: done pulses exactly once, 65 cycles after release; all 64 rd_value reads are in 0..4 and match a reference-model LFSR sequence from 16'hACE1.
- WRITE a=(2,3), value=4: cmd_ready drops, done pulses 2 cycles after accept; rd_value(2,3)=4; pixel (ORIGIN_X+100, ORIGIN_Y+70) gives value=4, top_left=(288,176), in_board=1 one cycle later.
- WRITE (0,0)=1 and (0,1)=3, then SWAP a=(0,0) b=(0,1): (0,0)=3, (0,1)=1. SWAP a=b=(5,5): cell unchanged, done still pulses.
- Pixel sweep: (191,112) and (448,200) give in_board=0, value=7; (192,112) gives top_left=(192,112); (447,367) gives top_left=(416,336); pixel_x_d equals pixel_x delayed exactly 1 cycle.
- cmd_valid held high with op FILL during a running FILL: not accepted until IDLE, then a second FILL runs and done pulses twice in total.
- reset_n pulsed low for 3 cycles mid-FILL (fill_cnt=30): cmd_ready=0, all cells 0 during reset; the fill restarts from cell 0 and completes in 65 cycles.
